gbe_tx_packetizer: RTL and testbench

- Sits directly downstream of the parallel test-pattern generator in the GbE write path.
- Buffers wide parallel words (din_valid-qualified) in an input FIFO.
- Once a full packet's worth is stored, emits a framed packet to the 10GbE TX core interface: optional header beat, payload serialized RATIO:1, tx_eof on the last beat.
- Tracks overflow and packet count for software readback.

---
 rtl/gbe_tx_packetizer.sv | 238 +++++++++++++++++++++++
 tb/tb_gbe_tx_packetizer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbe_tx_packetizer.sv
// -----------------------------------------------------------------------------
// gbe_tx_packetizer
//
// Buffers wide parallel words from the test-pattern generator in an input FIFO.
// Once a whole packet's worth of words is stored, it frames the packet for the
// 10GbE TX core: an optional header beat, then each stored word split into
// RATIO beats (lane 0 first), with tx_eof on the final beat.
//
// Optional feature macro: PKT_HEADER_EN
//   defined   -> one header beat {16'h5A5A, len, seq} precedes the payload
//   undefined -> payload only; seq still counts packets but is not emitted
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset (aborts any packet in flight)
//   en          write enable for the input side
//   pkt_len     payload length in input words, latched at packet start
//   din         parallel input word, DOUT_WIDTH*RATIO bits
//   din_valid   din qualifier
//   tx_afull    TX core almost-full; pauses output
//   tx_data     TX beat
//   tx_valid    tx_data qualifier
//   tx_eof      last beat of packet (only with tx_valid)
//   overflow    sticky: a din word was dropped because the FIFO was full
//   pkt_count   packets fully sent since reset
//   fifo_count  input words currently stored
// -----------------------------------------------------------------------------
module gbe_tx_packetizer #(
  parameter int DOUT_WIDTH = 64,
  parameter int RATIO      = 2,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [15:0]                   pkt_len,
  input  logic [DOUT_WIDTH*RATIO-1:0]   din,
  input  logic                          din_valid,
  input  logic                          tx_afull,
  output logic [DOUT_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  output logic                          tx_eof,
  output logic                          overflow,
  output logic [31:0]                   pkt_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIN_WIDTH = DOUT_WIDTH * RATIO;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;
  localparam int LW        = (RATIO > 1) ? $clog2(RATIO) : 1;

`ifdef PKT_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HEADER = 2'd1, PAYLOAD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd2} state_t;
`endif

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [DIN_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DIN_WIDTH-1:0] rd_data_reg;
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [AW-1:0]        rd_ptr_next;
  logic [AW-1:0]        rd_addr;
  logic [CW-1:0]        count_reg;
  logic                 overflow_reg;
  logic                 full;
  logic                 wr_en;
  logic                 rd_en;

  assign full        = (count_reg == CW'(FIFO_DEPTH));
  assign wr_en       = en & din_valid & ~full;
  assign rd_ptr_next = rd_en ? (rd_ptr_reg + AW'(1)) : rd_ptr_reg;
  // The RAM is addressed with the look-ahead pointer so rd_data_reg always
  // holds the word at the head of the FIFO on the cycle after a pop. This
  // keeps the payload gap-free across word boundaries.
  assign rd_addr     = rst ? '0 : rd_ptr_next;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
    rd_data_reg <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (en && din_valid && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Split the head word into output lanes.
  logic [DOUT_WIDTH-1:0] lane_data [RATIO];

  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign lane_data[gi] = rd_data_reg[gi*DOUT_WIDTH +: DOUT_WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Packet FSM. Output beats are registered, so a beat decided in cycle t is
  // visible in cycle t+1; a stall decision therefore shows up one cycle later.
  // ---------------------------------------------------------------------------
  state_t                state_reg, state_next;
  logic [15:0]           len_reg, len_next;
  logic [15:0]           word_idx_reg, word_idx_next;
  logic [LW-1:0]         lane_reg, lane_next;
  logic [31:0]           seq_reg, seq_next;
  logic [31:0]           pkt_count_reg, pkt_count_next;
  logic [DOUT_WIDTH-1:0] tx_data_reg, tx_data_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic                  tx_eof_reg, tx_eof_next;
  logic                  start_ok;
  logic                  lane_last;
  logic                  word_last;

  // pkt_len above FIFO_DEPTH can never be satisfied by fifo_count, so such a
  // request simply never starts.
  assign start_ok  = (pkt_len != 16'd0) &&
                     ({{(32-CW){1'b0}}, count_reg} >= {16'd0, pkt_len}) &&
                     !tx_afull;
  assign lane_last = (lane_reg == LW'(RATIO - 1));
  assign word_last = (word_idx_reg == (len_reg - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      word_idx_reg  <= '0;
      lane_reg      <= '0;
      seq_reg       <= '0;
      pkt_count_reg <= '0;
      tx_data_reg   <= '0;
      tx_valid_reg  <= 1'b0;
      tx_eof_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      word_idx_reg  <= word_idx_next;
      lane_reg      <= lane_next;
      seq_reg       <= seq_next;
      pkt_count_reg <= pkt_count_next;
      tx_data_reg   <= tx_data_next;
      tx_valid_reg  <= tx_valid_next;
      tx_eof_reg    <= tx_eof_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    word_idx_next  = word_idx_reg;
    lane_next      = lane_reg;
    seq_next       = seq_reg;
    pkt_count_next = pkt_count_reg;
    tx_data_next   = '0;
    tx_valid_next  = 1'b0;
    tx_eof_next    = 1'b0;
    rd_en          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          len_next      = pkt_len;
          word_idx_next = '0;
          lane_next     = '0;
`ifdef PKT_HEADER_EN
          state_next    = HEADER;
`else
          state_next    = PAYLOAD;
`endif
        end
      end

`ifdef PKT_HEADER_EN
      HEADER: begin
        if (!tx_afull) begin
          tx_valid_next       = 1'b1;
          tx_data_next[63:0]  = {16'h5A5A, len_reg, seq_reg};
          state_next          = PAYLOAD;
        end
      end
`endif

      PAYLOAD: begin
        if (!tx_afull) begin
          tx_valid_next = 1'b1;
          tx_data_next  = lane_data[lane_reg];
          if (lane_last) begin
            // Last lane of the head word: pop it so the next word is
            // presented by rd_data_reg on the following cycle.
            rd_en         = 1'b1;
            lane_next     = '0;
            word_idx_next = word_idx_reg + 16'd1;
            if (word_last) begin
              tx_eof_next    = 1'b1;
              seq_next       = seq_reg + 32'd1;
              pkt_count_next = pkt_count_reg + 32'd1;
              state_next     = IDLE;
            end
          end else begin
            lane_next = lane_reg + LW'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign tx_data    = tx_data_reg;
  assign tx_valid   = tx_valid_reg;
  assign tx_eof     = tx_eof_reg;
  assign overflow   = overflow_reg;
  assign pkt_count  = pkt_count_reg;
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_gbe_tx_packetizer.sv
// -----------------------------------------------------------------------------
// Testbench for gbe_tx_packetizer (DOUT_WIDTH=64, RATIO=2, FIFO_DEPTH=16).
// Accepted input words go into a reference queue; whenever the queue holds a
// full packet's worth, the expected beat stream for that packet is appended
// to a scoreboard. A negedge monitor pops and compares every tx_valid beat.
// -----------------------------------------------------------------------------
module tb_gbe_tx_packetizer;

  localparam int DW    = 64;
  localparam int RATIO = 2;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PKT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int PKT4_BEATS = 4 * RATIO + HDR;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic [15:0]           pkt_len;
  logic [DW*RATIO-1:0]   din;
  logic                  din_valid;
  logic                  tx_afull;
  logic [DW-1:0]         tx_data;
  logic                  tx_valid;
  logic                  tx_eof;
  logic                  overflow;
  logic [31:0]           pkt_count;
  logic [CW-1:0]         fifo_count;

  gbe_tx_packetizer #(
    .DOUT_WIDTH (DW),
    .RATIO      (RATIO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pkt_len    (pkt_len),
    .din        (din),
    .din_valid  (din_valid),
    .tx_afull   (tx_afull),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_eof     (tx_eof),
    .overflow   (overflow),
    .pkt_count  (pkt_count),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        eof;
    logic        pop;
  } beat_t;

  int tests = 0;
  int fails = 0;

  beat_t              exp_q[$];
  logic [DW*RATIO-1:0] model_fifo[$];
  int                 cur_len = 0;
  int                 occ = 0;
  int                 model_pkts = 0;
  logic [31:0]        model_seq = '0;
  bit                 exp_ovf = 1'b0;

  int cyc = 0;
  int wr_last_cyc = 0;
  int first_cyc = 0;
  int last_eof_cyc = 0;
  int last_gap = 0;
  int last_span = 0;
  int pkt_beats = 0;
  bit in_pkt = 1'b0;
  bit have_eof = 1'b0;
  bit prev_afull = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Whole packets are carved from the reference queue in arrival order.
  function automatic void gen_packets();
    logic [DW*RATIO-1:0] word;
    beat_t b;
    while (cur_len != 0 && model_fifo.size() >= cur_len) begin
`ifdef PKT_HEADER_EN
      b.data = {16'h5A5A, cur_len[15:0], model_seq};
      b.eof  = 1'b0;
      b.pop  = 1'b0;
      exp_q.push_back(b);
`endif
      for (int w = 0; w < cur_len; w++) begin
        word = model_fifo.pop_front();
        for (int k = 0; k < RATIO; k++) begin
          b.data = word[DW*k +: DW];
          b.eof  = (w == cur_len - 1) && (k == RATIO - 1);
          b.pop  = (k == RATIO - 1);
          exp_q.push_back(b);
        end
      end
      model_seq  = model_seq + 32'd1;
      model_pkts++;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst) begin
      if (tx_eof) check("eof_needs_valid", 64'(tx_valid), 64'd1);
      if (prev_afull) check("afull_stall", 64'(tx_valid), 64'd0);
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got 0x%0h expected no beat", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", tx_data, e.data);
          check("beat_eof", 64'(tx_eof), 64'(e.eof));
          if (e.pop) occ--;
        end
        if (!in_pkt) begin
          in_pkt    = 1'b1;
          first_cyc = cyc;
          if (have_eof) last_gap = cyc - last_eof_cyc;
        end
        pkt_beats++;
        if (tx_eof) begin
          in_pkt       = 1'b0;
          have_eof     = 1'b1;
          last_eof_cyc = cyc;
          last_span    = cyc - first_cyc + 1;
          pkt_beats    = 0;
        end
      end
    end
    prev_afull = tx_afull;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int n);
    pkt_len = 16'(n);
    cur_len = n;
    gen_packets();
  endtask

  task automatic drive(input logic e, input logic v, input logic [DW*RATIO-1:0] w);
    en        = e;
    din_valid = v;
    din       = w;
    tick();
    wr_last_cyc = cyc;
    if (e && v) begin
      if (occ < DEPTH) begin
        occ++;
        model_fifo.push_back(w);
        gen_packets();
      end else begin
        exp_ovf = 1'b1;
      end
    end
    en        = 1'b0;
    din_valid = 1'b0;
  endtask

  function automatic logic [DW*RATIO-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drain(input bit rnd);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) begin
      tx_afull = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
    end
    tx_afull = 1'b0;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) tick();
    check("fifo_count", 64'(fifo_count), 64'(model_fifo.size()));
    check("pkt_count", 64'(pkt_count), 64'(model_pkts));
    check("overflow", 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = '0; pkt_len = '0; tx_afull = 1'b0;
    repeat (3) tick();
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_eof", 64'(tx_eof), 64'd0);
    check("rst_tx_data", tx_data, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    rst = 1'b0;
    tick();

    // Basic packet, lanes {1,0},{3,2},{5,4},{7,6}; start latency and span.
    set_len(4);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, {64'(2*i+1), 64'(2*i)});
    drain(1'b0);
    check("start_latency", 64'(first_cyc - wr_last_cyc), 64'd2);
    check("basic_span", 64'(last_span), 64'(PKT4_BEATS));

    // Back-to-back packets with exactly one idle cycle between them.
    tx_afull = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, rand_word());
    tx_afull = 1'b0;
    drain(1'b0);
    check("b2b_gap", 64'(last_gap), 64'd2);
    check("b2b_span", 64'(last_span), 64'(PKT4_BEATS));

    // Backpressure for 5 cycles mid-packet.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, rand_word());
    for (int i = 0; i < 100 && pkt_beats < 3; i++) tick();
    check("bp_trigger", 64'(pkt_beats >= 3), 64'd1);
    tx_afull = 1'b1;
    repeat (5) tick();
    tx_afull = 1'b0;
    drain(1'b0);
    check("bp_span", 64'(last_span), 64'(PKT4_BEATS + 5));

    // pkt_len = 0 never starts; en low ignores writes.
    set_len(0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, rand_word());
    drive(1'b0, 1'b1, rand_word());
    repeat (20) tick();
    check("len0_hold", 64'(fifo_count), 64'(occ));

    // Randomised phases: gaps, en low, random backpressure, varying lengths.
    for (int p = 0; p < 8; p++) begin
      int n;
      int written;
      logic e;
      logic v;
      set_len($urandom_range(1, 6));
      n = $urandom_range(0, DEPTH - occ);
      written = 0;
      for (int g = 0; g < 400 && written < n; g++) begin
        e = ($urandom_range(0, 3) != 0);
        v = ($urandom_range(0, 3) != 0);
        tx_afull = ($urandom_range(0, 4) == 0);
        drive(e, v, rand_word());
        if (e && v) written++;
      end
      drain(1'b1);
    end

    // Overflow: output held off while 20 words are offered.
    tx_afull = 1'b1;
    set_len(4);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, rand_word());
    check("ovf_fifo_count", 64'(fifo_count), 64'(DEPTH));
    check("ovf_flag", 64'(overflow), 64'd1);
    drain(1'b1);

    // Reset in the middle of a packet.
    tx_afull = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, rand_word());
    tx_afull = 1'b0;
    for (int i = 0; i < 100 && pkt_beats < 3; i++) tick();
    check("rst_trigger", 64'(pkt_beats >= 3), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_fifo.delete();
    occ = 0; model_pkts = 0; model_seq = '0; exp_ovf = 1'b0;
    in_pkt = 1'b0; pkt_beats = 0; have_eof = 1'b0;
    check("mid_rst_valid", 64'(tx_valid), 64'd0);
    check("mid_rst_eof", 64'(tx_eof), 64'd0);
    check("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
    check("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    repeat (2) tick();
    check("mid_rst_no_eof_after", 64'(pkt_count), 64'd0);

    // Next packet restarts at seq 0.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, rand_word());
    drain(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
